// File: rtl/hid_pad_pkg.sv
// Shared constants and helpers for the HID gamepad report decoder:
// button bit positions for both console maps, axis thresholds, frame FSM states.
package hid_pad_pkg;

  localparam int VEC_W  = 12;
  localparam int BCNT_W = 4;

  localparam logic [1:0] AXIS_LO = 2'b00;
  localparam logic [1:0] AXIS_HI = 2'b11;

  // SNES vector positions
  localparam int BIT_B     = 0;
  localparam int BIT_Y     = 1;
  localparam int BIT_SEL   = 2;
  localparam int BIT_STA   = 3;
  localparam int BIT_UP    = 4;
  localparam int BIT_DOWN  = 5;
  localparam int BIT_LEFT  = 6;
  localparam int BIT_RIGHT = 7;
  localparam int BIT_A     = 8;
  localparam int BIT_X     = 9;
  localparam int BIT_L     = 10;
  localparam int BIT_R     = 11;

  // NES vector positions; bits 11:8 stay zero
  localparam int NES_A     = 0;
  localparam int NES_B     = 1;
  localparam int NES_SEL   = 2;
  localparam int NES_STA   = 3;
  localparam int NES_RIGHT = 4;
  localparam int NES_LEFT  = 5;
  localparam int NES_DOWN  = 6;
  localparam int NES_UP    = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } frame_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic a;
    logic b;
    logic x;
    logic y;
    logic l;
    logic r;
    logic sel;
    logic sta;
  } pad_fields_t;

  function automatic logic [VEC_W-1:0] pack_vec(input pad_fields_t f, input logic snes);
    logic [VEC_W-1:0] v;
    v = '0;
    if (snes) begin
      v[BIT_B]     = f.b;
      v[BIT_Y]     = f.y;
      v[BIT_SEL]   = f.sel;
      v[BIT_STA]   = f.sta;
      v[BIT_UP]    = f.up;
      v[BIT_DOWN]  = f.down;
      v[BIT_LEFT]  = f.left;
      v[BIT_RIGHT] = f.right;
      v[BIT_A]     = f.a;
      v[BIT_X]     = f.x;
      v[BIT_L]     = f.l;
      v[BIT_R]     = f.r;
    end else begin
      v[NES_A]     = f.a;
      v[NES_B]     = f.b;
      v[NES_SEL]   = f.sel;
      v[NES_STA]   = f.sta;
      v[NES_RIGHT] = f.right;
      v[NES_LEFT]  = f.left;
      v[NES_DOWN]  = f.down;
      v[NES_UP]    = f.up;
    end
    return v;
  endfunction

endpackage

// File: rtl/hid_pad_slot.sv
// One controller slot: held button vector, valid flag and inactivity timer.
// Priority is clear > commit > timeout.
module hid_pad_slot
  import hid_pad_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1200000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             commit_i,
  input  logic [VEC_W-1:0] vec_i,
  input  logic             clr_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             ok_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             ok_q, ok_d;
  logic             expire_s;

  // the counter lands on T_MAX in the same cycle the slot clears
  assign expire_s = (cnt_q >= T_PRE);

  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    ok_d  = ok_q;
    if (commit_i) begin
      cnt_d = '0;
    end else if (expire_s) begin
      cnt_d = T_MAX;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr_i) begin
      vec_d = '0;
      ok_d  = 1'b0;
    end else if (commit_i) begin
      vec_d = vec_i;
      ok_d  = 1'b1;
    end else if (expire_s) begin
      vec_d = '0;
      ok_d  = 1'b0;
    end else begin
      vec_d = vec_q;
      ok_d  = ok_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      vec_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      ok_q  <= ok_d;
    end
  end

  assign vec_o = vec_q;
  assign ok_o  = ok_q;

endmodule

// File: rtl/hid_pad_decoder.sv
// Decodes framed USB HID gamepad reports into held per-pad button vectors,
// with channel routing, short-frame rejection, inactivity timeout and error clearing.
module hid_pad_decoder
  import hid_pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int SNES_MODE   = 0,
  parameter int Y_BYTE      = 3,
  parameter int X_BYTE      = 4,
  parameter int BTN0_BYTE   = 5,
  parameter int BTN1_BYTE   = 6,
  parameter int TIMEOUT_CYC = 1200000,
  localparam int CH_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                      usbclk,
  input  logic                      usbrst,
  input  logic                      rpt_rdy,
  input  logic                      rpt_stb,
  input  logic [7:0]                rpt_dat,
  input  logic [CH_W-1:0]           rpt_ch,
  input  logic                      conerr,
  output logic [VEC_W*NUM_PADS-1:0] btn,
  output logic [NUM_PADS-1:0]       pad_ok,
  output logic                      frame_stb
);

  localparam int MAX_AB   = (Y_BYTE > X_BYTE) ? Y_BYTE : X_BYTE;
  localparam int MAX_CD   = (BTN0_BYTE > BTN1_BYTE) ? BTN0_BYTE : BTN1_BYTE;
  localparam int MAX_BYTE = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BYTE);
  localparam logic [CH_W:0]     NP_LIM  = (CH_W + 1)'(NUM_PADS);

  frame_state_e      state_q, state_d;
  logic              rdy_q, stb_q, armed_q, frame_stb_q;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  pad_fields_t       fld_q, fld_d;
  logic              rdy_rise_s, rdy_fall_s, stb_rise_s, commit_s;
  logic [VEC_W-1:0]  vec_s;

  // armed_q suppresses a bogus rise when rpt_rdy is already high out of reset
  assign rdy_rise_s = rpt_rdy & ~rdy_q & armed_q;
  assign rdy_fall_s = ~rpt_rdy & rdy_q;
  assign stb_rise_s = rpt_stb & ~stb_q;
  assign vec_s      = pack_vec(fld_q, SNES_MODE != 0);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    fld_d    = fld_q;
    commit_s = 1'b0;
    if (conerr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy_rise_s) begin
            state_d = ST_RECV;
            ch_d    = rpt_ch;
            cnt_d   = '0;
            fld_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RECV: begin
          if (rdy_fall_s) begin
            state_d  = ST_IDLE;
            commit_s = (cnt_q > MAX_CNT) && ({1'b0, ch_q} < NP_LIM);
          end else if (stb_rise_s && rpt_rdy) begin
            if (cnt_q != 4'hF) begin
              cnt_d = cnt_q + 4'h1;
            end else begin
              cnt_d = cnt_q;
            end
            // each axis byte rewrites both of its bits, so centre releases
            if (cnt_q == BCNT_W'(Y_BYTE)) begin
              fld_d.down = (rpt_dat[7:6] == AXIS_LO);
              fld_d.up   = (rpt_dat[7:6] == AXIS_HI);
            end else if (cnt_q == BCNT_W'(X_BYTE)) begin
              fld_d.left  = (rpt_dat[7:6] == AXIS_LO);
              fld_d.right = (rpt_dat[7:6] == AXIS_HI);
            end else if (cnt_q == BCNT_W'(BTN0_BYTE)) begin
              fld_d.x = rpt_dat[4];
              fld_d.a = rpt_dat[5];
              fld_d.b = rpt_dat[6];
              fld_d.y = rpt_dat[7];
            end else if (cnt_q == BCNT_W'(BTN1_BYTE)) begin
              fld_d.l   = rpt_dat[0];
              fld_d.r   = rpt_dat[1];
              fld_d.sel = rpt_dat[4];
              fld_d.sta = rpt_dat[5];
            end else begin
              fld_d = fld_q;
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      stb_q       <= 1'b0;
      armed_q     <= 1'b0;
      frame_stb_q <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      fld_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rpt_rdy;
      stb_q       <= rpt_stb;
      armed_q     <= armed_q | ~rpt_rdy;
      frame_stb_q <= commit_s;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      fld_q       <= fld_d;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_slot
    hid_pad_slot #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_slot (
      .clk_i    (usbclk),
      .rst_i    (usbrst),
      .commit_i (commit_s && (ch_q == CH_W'(p))),
      .vec_i    (vec_s),
      .clr_i    (conerr),
      .vec_o    (btn[VEC_W*p +: VEC_W]),
      .ok_o     (pad_ok[p])
    );
  end

  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_hid_pad_decoder.sv
// Drives identical report streams into an SNES-map and an NES-map decoder and
// checks held vectors, pad_ok, frame_stb pulses, timeout and error clearing.
module tb_hid_pad_decoder;

  localparam int NP = 3;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        usbrst = 1'b1, rdy = 1'b0, stb = 1'b0, conerr = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic [1:0]  ch = 2'd0;
  logic [35:0] btn_s, btn_n;
  logic [2:0]  ok_s, ok_n;
  logic        fs_s, fs_n;

  always #5 clk = ~clk;

  hid_pad_decoder #(.NUM_PADS(NP), .SNES_MODE(1), .TIMEOUT_CYC(TO)) dut (
    .usbclk(clk), .usbrst(usbrst), .rpt_rdy(rdy), .rpt_stb(stb), .rpt_dat(dat),
    .rpt_ch(ch), .conerr(conerr), .btn(btn_s), .pad_ok(ok_s), .frame_stb(fs_s));

  hid_pad_decoder #(.NUM_PADS(NP), .SNES_MODE(0), .TIMEOUT_CYC(TO)) dut_nes (
    .usbclk(clk), .usbrst(usbrst), .rpt_rdy(rdy), .rpt_stb(stb), .rpt_dat(dat),
    .rpt_ch(ch), .conerr(conerr), .btn(btn_n), .pad_ok(ok_n), .frame_stb(fs_n));

  typedef struct { int pad; logic [11:0] vs; logic [11:0] vn; } exp_t;
  typedef struct { logic [35:0] bs; logic [35:0] bn; logic [2:0] ok; logic stb_s; logic stb_n; } obs_t;
  typedef struct {
    logic [1:0] ch; logic [7:0] b3; logic [7:0] b4; logic [7:0] b5; logic [7:0] b6;
    int n; logic commit; logic [11:0] vs; logic [11:0] vn;
  } vec_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int          rd_idx = 0;
  int          total = 0, bad = 0;
  logic [11:0] m_s[NP], m_n[NP];
  logic        m_ok[NP];
  vec_t        tbl[9];

  // record every frame_stb cycle of either decoder
  always @(negedge clk) begin
    if (fs_s || fs_n) obs_q.push_back('{btn_s, btn_n, ok_s, fs_s, fs_n});
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic check_all(input string name);
    logic [35:0] es, en;
    logic [2:0]  eo;
    for (int p = 0; p < NP; p++) begin
      es[12*p +: 12] = m_s[p];
      en[12*p +: 12] = m_n[p];
      eo[p]          = m_ok[p];
    end
    check({name, "_btn_snes"}, btn_s, es);
    check({name, "_btn_nes"}, btn_n, en);
    check({name, "_ok_snes"}, ok_s, eo);
    check({name, "_ok_nes"}, ok_n, eo);
  endtask

  task automatic check_sb(input string name);
    obs_t o;
    exp_t e;
    while (rd_idx < obs_q.size()) begin
      o = obs_q[rd_idx];
      rd_idx++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_extra_stb: got frame_stb=1 want 0", name);
      end else begin
        e = exp_q.pop_front();
        check({name, "_stb_snes"}, o.stb_s, 1);
        check({name, "_stb_nes"}, o.stb_n, 1);
        check({name, "_vec_snes"}, o.bs[12*e.pad +: 12], e.vs);
        check({name, "_vec_nes"}, o.bn[12*e.pad +: 12], e.vn);
        check({name, "_stb_ok"}, o.ok[e.pad], 1);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s_missing_stb: got frame_stb=0 want 1 (pad %0d)", name, e.pad);
    end
  endtask

  task automatic expect_commit(input int pad, input logic [11:0] vs, input logic [11:0] vn);
    exp_q.push_back('{pad, vs, vn});
    m_s[pad]  = vs;
    m_n[pad]  = vn;
    m_ok[pad] = 1'b1;
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin m_s[p] = 12'h000; m_n[p] = 12'h000; m_ok[p] = 1'b0; end
  endtask

  function automatic logic [7:0] byte_val(input int i, input logic [7:0] b3, input logic [7:0] b4,
                                          input logic [7:0] b5, input logic [7:0] b6);
    case (i)
      3: return b3;
      4: return b4;
      5: return b5;
      6: return b6;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d);
    dat = d; stb = 1'b1; tick(1);
    stb = 1'b0; tick(1);
  endtask

  // returns 1 ns after the edge that samples the rpt_rdy fall
  task automatic send_frame(input logic [1:0] c, input logic [7:0] b3, input logic [7:0] b4,
                            input logic [7:0] b5, input logic [7:0] b6, input int n);
    ch = c; rdy = 1'b1; tick(2);
    for (int i = 0; i < n; i++) send_byte(byte_val(i, b3, b4, b5, b6));
    rdy = 1'b0; tick(1);
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'h00, 8'hFF, 8'h60, 8'h30, 8, 1'b1, 12'h1AD, 12'h05F};
    tbl[1] = '{2'd0, 8'h00, 8'hFF, 8'h60, 8'h30, 5, 1'b0, 12'h000, 12'h000};
    tbl[2] = '{2'd0, 8'h80, 8'h80, 8'h00, 8'h00, 8, 1'b1, 12'h000, 12'h000};
    tbl[3] = '{2'd1, 8'h80, 8'h80, 8'h20, 8'h00, 8, 1'b1, 12'h100, 12'h001};
    tbl[4] = '{2'd3, 8'h00, 8'h00, 8'hFF, 8'hFF, 8, 1'b0, 12'h000, 12'h000};
    tbl[5] = '{2'd2, 8'hFF, 8'h00, 8'h90, 8'h03, 8, 1'b1, 12'hE52, 12'h0A0};
    tbl[6] = '{2'd0, 8'hC0, 8'h3F, 8'h40, 8'h10, 7, 1'b1, 12'h055, 12'h0A6};
    tbl[7] = '{2'd0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 6, 1'b0, 12'h000, 12'h000};
    tbl[8] = '{2'd0, 8'h40, 8'hBF, 8'hA0, 8'h20, 8, 1'b1, 12'h10A, 12'h009};
    clear_model();

    // reset with rpt_rdy already high: no rise, so that frame is ignored
    rdy = 1'b1;
    tick(3);
    check_all("reset");
    check("reset_stb", fs_s, 0);
    usbrst = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(byte_val(i, 8'h00, 8'hFF, 8'h60, 8'h30));
    rdy = 1'b0;
    tick(3);
    check_sb("rdy_at_reset");
    check_all("rdy_at_reset");

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].commit) expect_commit(int'(tbl[i].ch), tbl[i].vs, tbl[i].vn);
      send_frame(tbl[i].ch, tbl[i].b3, tbl[i].b4, tbl[i].b5, tbl[i].b6, tbl[i].n);
      tick(2);
      check_sb($sformatf("vec%0d", i));
      check_all($sformatf("vec%0d", i));
    end

    // timeout lands exactly TO cycles after the commit edge
    expect_commit(0, 12'h1AD, 12'h05F);
    send_frame(2'd0, 8'h00, 8'hFF, 8'h60, 8'h30, 8);
    tick(TO - 1);
    check("to_before_ok", ok_s[0], 1);
    tick(1);
    check("to_clear_ok", ok_s[0], 0);
    check("to_clear_btn", btn_s[11:0], 0);
    check_sb("timeout");
    clear_model();
    check_all("timeout");

    // a commit on the saturating cycle keeps the pad valid
    expect_commit(0, 12'h1AD, 12'h05F);
    send_frame(2'd0, 8'h00, 8'hFF, 8'h60, 8'h30, 8);
    tick(TO - 19);
    expect_commit(0, 12'h055, 12'h0A6);
    send_frame(2'd0, 8'hC0, 8'h3F, 8'h40, 8'h10, 8);
    check("to_race_ok", ok_s[0], 1);
    check("to_race_btn", btn_s[11:0], 12'h055);
    tick(1);
    check_sb("to_race");
    check_all("to_race");

    // conerr mid-frame clears everything and abandons the frame
    ch = 2'd0; rdy = 1'b1; tick(2);
    for (int i = 0; i < 4; i++) send_byte(byte_val(i, 8'h00, 8'hFF, 8'hFF, 8'hFF));
    conerr = 1'b1; tick(1); conerr = 1'b0;
    clear_model();
    check_all("conerr");
    for (int i = 4; i < 8; i++) send_byte(byte_val(i, 8'h00, 8'hFF, 8'hFF, 8'hFF));
    rdy = 1'b0; tick(3);
    check_sb("conerr_tail");
    check_all("conerr_tail");
    expect_commit(1, 12'h100, 12'h001);
    send_frame(2'd1, 8'h80, 8'h80, 8'h20, 8'h00, 8);
    tick(2);
    check_sb("conerr_next");
    check_all("conerr_next");

    // conerr in the rdy-fall cycle beats the commit
    ch = 2'd2; rdy = 1'b1; tick(2);
    for (int i = 0; i < 8; i++) send_byte(byte_val(i, 8'hFF, 8'h00, 8'h90, 8'h03));
    rdy = 1'b0; conerr = 1'b1; tick(1); conerr = 1'b0;
    tick(2);
    clear_model();
    check_sb("conerr_commit");
    check_all("conerr_commit");

    // reset mid-frame discards it; rpt_rdy still high afterwards gives no rise
    expect_commit(2, 12'hE52, 12'h0A0);
    send_frame(2'd2, 8'hFF, 8'h00, 8'h90, 8'h03, 8);
    tick(2);
    check_sb("pre_rst");
    check_all("pre_rst");
    ch = 2'd0; rdy = 1'b1; tick(2);
    for (int i = 0; i < 3; i++) send_byte(byte_val(i, 8'h00, 8'hFF, 8'h60, 8'h30));
    usbrst = 1'b1; tick(2);
    clear_model();
    check_all("rst_mid");
    usbrst = 1'b0;
    for (int i = 3; i < 8; i++) send_byte(byte_val(i, 8'h00, 8'hFF, 8'h60, 8'h30));
    rdy = 1'b0; tick(3);
    check_sb("rst_tail");
    check_all("rst_tail");
    expect_commit(0, 12'h10A, 12'h009);
    send_frame(2'd0, 8'h40, 8'hBF, 8'hA0, 8'h20, 8);
    tick(2);
    check_sb("rst_next");
    check_all("rst_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
